// File: rtl/register_bank.sv
// DEPTH x WIDTH register file: one write port, two combinational read ports, optional write forwarding, hardware clear sweep.
// Writes land one active edge later (or same cycle when forwarded); writes are dropped while busy, never stalled.
module register_bank #(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 3,
    parameter bit NEGEDGE = 1'b0,
    parameter bit BYPASS  = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              clr,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [WIDTH-1:0]  mem     [DEPTH];
    logic [WIDTH-1:0]  mem_nxt [DEPTH];
    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              wr_ok;

    assign busy  = (state == SWEEP);
    assign wr_ok = we && !busy;

    always_comb begin
        mem_nxt   = mem;
        state_nxt = state;
        ptr_nxt   = ptr;
        if (state == IDLE) begin
            // A write coinciding with the clear request still lands; the sweep erases it later.
            if (we) begin
                mem_nxt[waddr] = wdata;
            end
            if (clr) begin
                state_nxt = SWEEP;
                ptr_nxt   = '0;
            end
        end else begin
            mem_nxt[ptr] = '0;
            ptr_nxt      = ptr + 1'b1;
            if (ptr == LAST) begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        end
    end

    generate
        if (NEGEDGE) begin : g_neg
            always_ff @(negedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                    state <= IDLE;
                    ptr   <= '0;
                end else begin
                    mem   <= mem_nxt;
                    state <= state_nxt;
                    ptr   <= ptr_nxt;
                end
            end
        end else begin : g_pos
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                    state <= IDLE;
                    ptr   <= '0;
                end else begin
                    mem   <= mem_nxt;
                    state <= state_nxt;
                    ptr   <= ptr_nxt;
                end
            end
        end
    endgenerate

    // Forwarding is suppressed in reset so the outputs read zero there.
    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
        if (BYPASS && reset_n && wr_ok && (waddr == raddr_a)) rdata_a = wdata;
        if (BYPASS && reset_n && wr_ok && (waddr == raddr_b)) rdata_b = wdata;
    end

endmodule

// File: tb/tb_register_bank.sv
// Drives a rising-edge/no-forward bank and a falling-edge/forwarding bank from the same inputs against a scoreboard.
module tb_register_bank;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic        clr = 1'b0;
    logic [2:0]  raddr_a = '0;
    logic [2:0]  raddr_b = '0;
    logic [15:0] rd_a0, rd_b0, rd_a1, rd_b1;
    logic        busy0, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_bank #(.WIDTH(16), .ADDR_W(3), .NEGEDGE(1'b0), .BYPASS(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a0), .rdata_b(rd_b0), .busy(busy0)
    );

    register_bank #(.WIDTH(16), .ADDR_W(3), .NEGEDGE(1'b1), .BYPASS(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a1), .rdata_b(rd_b1), .busy(busy1)
    );

    typedef struct {
        string       nm;
        logic [15:0] pa0, pb0, pa1, pb1;
        logic        pbusy;
        logic [15:0] qa0, qb0;
        logic        qbusy0;
    } exp_t;

    exp_t sb[$];

    // Reference model: register contents, whether a clear is running, how many entries it has erased.
    logic [15:0] m [8];
    bit          m_busy = 1'b0;
    int          m_done = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: inputs are applied between the falling and the next rising edge.
    task automatic op(input string nm, input bit rst_n, input bit w, input int wa,
                      input logic [15:0] wd, input bit c, input int ra, input int rb);
        exp_t e;
        @(negedge clk);
        #2;
        reset_n = rst_n;
        we      = w;
        waddr   = wa[2:0];
        wdata   = wd;
        clr     = c;
        raddr_a = ra[2:0];
        raddr_b = rb[2:0];
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m[i] = '0;
            m_busy = 1'b0;
            m_done = 0;
        end
        e.nm    = nm;
        e.pa0   = m[ra];
        e.pb0   = m[rb];
        e.pa1   = (rst_n && w && !m_busy && wa == ra) ? wd : m[ra];
        e.pb1   = (rst_n && w && !m_busy && wa == rb) ? wd : m[rb];
        e.pbusy = m_busy;
        if (rst_n) begin
            if (m_busy) begin
                m[m_done] = '0;
                m_done++;
                if (m_done == 8) begin
                    m_busy = 1'b0;
                    m_done = 0;
                end
            end else begin
                if (w) m[wa] = wd;
                if (c) begin
                    m_busy = 1'b1;
                    m_done = 0;
                end
            end
        end
        e.qa0    = m[ra];
        e.qb0    = m[rb];
        e.qbusy0 = m_busy;
        sb.push_back(e);
    endtask

    // Monitor: pre-edge sample just after stimulus, post-edge sample between rising and falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.nm, " pre a0"}, rd_a0, e.pa0);
                chk({e.nm, " pre b0"}, rd_b0, e.pb0);
                chk({e.nm, " pre busy0"}, {15'd0, busy0}, {15'd0, e.pbusy});
                chk({e.nm, " pre a1"}, rd_a1, e.pa1);
                chk({e.nm, " pre b1"}, rd_b1, e.pb1);
                chk({e.nm, " pre busy1"}, {15'd0, busy1}, {15'd0, e.pbusy});
                @(posedge clk);
                #2;
                chk({e.nm, " post a0"}, rd_a0, e.qa0);
                chk({e.nm, " post b0"}, rd_b0, e.qb0);
                chk({e.nm, " post busy0"}, {15'd0, busy0}, {15'd0, e.qbusy0});
                chk({e.nm, " post a1"}, rd_a1, e.pa1);
                chk({e.nm, " post b1"}, rd_b1, e.pb1);
                chk({e.nm, " post busy1"}, {15'd0, busy1}, {15'd0, e.pbusy});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) m[i] = '0;

        op("reset_init", 0, 0, 0, 16'h0, 0, 0, 1);
        for (int i = 0; i < 8; i++) op("fill_ffff", 1, 1, i, 16'hFFFF, 0, i, 7 - i);
        op("reset_async", 0, 0, 0, 16'h0, 0, 3, 6);
        op("reset_hold", 0, 1, 3, 16'h1111, 0, 3, 3);

        op("pre3", 1, 1, 3, 16'b1010101000001111, 0, 3, 4);
        op("pre4", 1, 1, 4, 16'h4444, 0, 3, 4);
        op("pre5", 1, 1, 5, 16'h5555, 0, 4, 5);
        op("write3", 1, 1, 3, 16'hACAC, 0, 3, 3);
        op("hold3", 1, 0, 3, 16'hFFFF, 0, 3, 4);
        op("bypass2", 1, 1, 2, 16'h1234, 0, 2, 5);
        op("read2", 1, 0, 0, 16'h0, 0, 2, 3);

        for (int i = 0; i < 8; i++) op("fill_idx", 1, 1, i, 16'(i + 1), 0, i, (i + 1) % 8);
        op("clr", 1, 0, 0, 16'h0, 1, 0, 7);
        for (int k = 0; k < 8; k++)
            op("sweep", 1, k == 2 || k == 5, k == 5 ? 3 : 7, 16'hBEEF, k == 4, k, k == 5 ? 3 : 7);
        op("after_sweep", 1, 0, 0, 16'h0, 0, 7, 0);

        op("clr_with_wr", 1, 1, 5, 16'h5A5A, 1, 5, 5);
        for (int k = 0; k < 8; k++) op("sweep6", 1, 0, 0, 16'h0, 0, 5, k);
        op("wr_after", 1, 1, 1, 16'h7777, 0, 1, 5);
        op("rd_after", 1, 0, 0, 16'h0, 0, 1, 5);

        for (int i = 0; i < 8; i++) op("fill_c", 1, 1, i, 16'hC000 | 16'(i), 0, i, 0);
        op("clr_r", 1, 0, 0, 16'h0, 1, 0, 2);
        op("sweep_r", 1, 0, 0, 16'h0, 0, 0, 3);
        op("sweep_r", 1, 0, 0, 16'h0, 0, 1, 3);
        op("reset_mid", 0, 0, 0, 16'h0, 0, 6, 7);
        op("fill_after_rst", 1, 1, 0, 16'h0A0A, 0, 0, 1);
        op("fill_after_rst", 1, 1, 1, 16'h0B0B, 0, 0, 1);
        op("clr_again", 1, 0, 0, 16'h0, 1, 0, 1);
        for (int k = 0; k < 9; k++) op("sweep_again", 1, 0, 0, 16'h0, 0, 0, 1);

        for (int n = 0; n < 300; n++) begin
            op("random", $urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1,
               int'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 9) == 0,
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
